// File: rtl/serial_add_ctrl_pkg.sv
// Shared types and defaults for the bit-serial adder sequencer.
package serial_add_pkg;

    localparam int WIDTH_DEF = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADD  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/serial_add_ctrl_fa_cell.sv
// One-bit full adder; the only arithmetic element of the serial adder.
module fa_cell (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);

    assign sum  = a ^ b ^ cin;
    assign cout = (a & b) | (b & cin) | (cin & a);

endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder sequencer: WIDTH-bit add over WIDTH cycles, LSB first.
// Optional subtract support is enabled by defining SERIAL_ADD_SUB_EN.
module serial_add_ctrl
    import serial_add_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
`ifdef SERIAL_ADD_SUB_EN
    input  logic             sub,
`endif
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_t           state, state_n;
    logic [WIDTH-1:0] sa, sb;
    logic [WIDTH-2:0] acc;
    logic [WIDTH-1:0] acc_full;
    logic [CW-1:0]    cnt;
    logic             carry;
    logic             cell_b, cell_s, cell_c;

`ifdef SERIAL_ADD_SUB_EN
    logic sub_q;
    assign cell_b = sb[0] ^ sub_q;
`else
    assign cell_b = sb[0];
`endif

    fa_cell u_fa (
        .a    (sa[0]),
        .b    (cell_b),
        .cin  (carry),
        .sum  (cell_s),
        .cout (cell_c)
    );

    // acc keeps only the bits already computed; this cycle's bit completes the word
    assign acc_full = {cell_s, acc};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_n;
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE:    if (start) state_n = ADD;
            ADD:     if (cnt == LAST) state_n = DONE;
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy  <= 1'b0;
            done  <= 1'b0;
            sum   <= '0;
            cout  <= 1'b0;
            sa    <= '0;
            sb    <= '0;
            acc   <= '0;
            cnt   <= '0;
            carry <= 1'b0;
`ifdef SERIAL_ADD_SUB_EN
            sub_q <= 1'b0;
`endif
        end else begin
            busy <= (state_n == ADD);
            done <= (state_n == DONE);
            case (state)
                IDLE: begin
                    if (start) begin
                        sa  <= a;
                        sb  <= b;
                        cnt <= '0;
`ifdef SERIAL_ADD_SUB_EN
                        sub_q <= sub;
                        // two's-complement subtract: invert b and add one via carry-in
                        carry <= sub ? 1'b1 : cin;
`else
                        carry <= cin;
`endif
                    end
                end
                ADD: begin
                    sa    <= sa >> 1;
                    sb    <= sb >> 1;
                    acc   <= acc_full[WIDTH-1:1];
                    carry <= cell_c;
                    cnt   <= cnt + CW'(1);
                    if (cnt == LAST) begin
                        sum  <= acc_full;
                        cout <= cell_c;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Directed-vector bench for serial_add_ctrl (WIDTH=8), including the optional subtract mode.
module tb_serial_add_ctrl;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [W-1:0] a, b;
    logic         cin;
    logic         sub;
    logic         busy, done, cout;
    logic [W-1:0] sum;

    int n_cmp = 0;
    int n_bad = 0;

    serial_add_ctrl #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .cin   (cin),
`ifdef SERIAL_ADD_SUB_EN
        .sub   (sub),
`endif
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Launch one operation, scramble inputs after acceptance, then wait for done.
    task automatic run_op(input string tag, input logic [W-1:0] ia, input logic [W-1:0] ib,
                          input logic ic, input logic isub,
                          input logic [W-1:0] exp_sum, input logic exp_cout);
        int cyc;
        int bcnt;
        a = ia; b = ib; cin = ic; sub = isub; start = 1'b1;
        tick();
        start = 1'b0;
        a = ~ia; b = ~ib; cin = ~ic; sub = ~isub;
        cyc = 0; bcnt = 0;
        while (!done && cyc < 20) begin
            if (busy) bcnt++;
            tick();
            cyc++;
        end
        check({tag, " latency"}, cyc, W);
        check({tag, " busy_cycles"}, bcnt, W);
        check({tag, " sum"}, sum, exp_sum);
        check({tag, " cout"}, cout, exp_cout);
        check({tag, " busy_at_done"}, busy, 0);
        tick();
        check({tag, " done_one_cycle"}, done, 0);
    endtask

    initial begin
        int done_cnt;
        rst = 1'b1; start = 1'b0; a = '0; b = '0; cin = 1'b0; sub = 1'b0;
        tick(); tick();
        check("reset busy", busy, 0);
        check("reset done", done, 0);
        check("reset sum", sum, 0);
        check("reset cout", cout, 0);
        rst = 1'b0;
        tick();

        run_op("add_5a_33", 8'h5A, 8'h33, 1'b0, 1'b0, 8'h8D, 1'b0);
        run_op("add_ff_01", 8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1);

        // start re-pulsed while busy, then held high through DONE
        a = 8'h12; b = 8'h34; cin = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        done_cnt = 0;
        for (int c = 0; c < 22; c++) begin
            if (c == 3) begin a = 8'h00; b = 8'h00; start = 1'b1; end
            if (c == 11) start = 1'b0;
            if (done) begin
                done_cnt++;
                if (done_cnt == 1) begin
                    check("busy_start first_done_cycle", c, W);
                    check("busy_start first_sum", sum, 8'h46);
                end else begin
                    check("busy_start second_done_cycle", c, 2 * W + 2);
                    check("busy_start second_sum", sum, 8'h00);
                end
            end
            if (c == 15) check("busy_start sum_held", sum, 8'h46);
            tick();
        end
        check("busy_start done_count", done_cnt, 2);

        run_op("add_ff_ff_c1", 8'hFF, 8'hFF, 1'b1, 1'b0, 8'hFF, 1'b1);

        // reset in the middle of an operation
        a = 8'hAA; b = 8'h55; cin = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        tick(); tick(); tick(); tick();
        check("abort busy_before", busy, 1);
        rst = 1'b1;
        #1;
        check("abort busy", busy, 0);
        check("abort sum", sum, 0);
        check("abort cout", cout, 0);
        check("abort done", done, 0);
        tick();
        rst = 1'b0;
        done_cnt = 0;
        for (int c = 0; c < 12; c++) begin
            if (done) done_cnt++;
            tick();
        end
        check("abort no_done", done_cnt, 0);

        run_op("post_reset_01_02", 8'h01, 8'h02, 1'b0, 1'b0, 8'h03, 1'b0);

`ifdef SERIAL_ADD_SUB_EN
        run_op("sub_10_01", 8'h10, 8'h01, 1'b0, 1'b1, 8'h0F, 1'b1);
        run_op("sub_01_02", 8'h01, 8'h02, 1'b0, 1'b1, 8'hFF, 1'b0);
        run_op("sub0_add_5a_33", 8'h5A, 8'h33, 1'b0, 1'b0, 8'h8D, 1'b0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/serial_add_ctrl.md
# serial_add_ctrl

- Bit-serial adder sequencer: one single-bit full-adder cell computes a WIDTH-bit sum over WIDTH clock cycles, one bit per cycle, LSB first.
- A carry flip-flop links the cycles.
- Sits between a requester (start/operands) and the one-bit full-adder datapath, trading latency for area.
- Result and carry-out are presented with a one-cycle done pulse and held until the next accepted operation completes.

## Interface
- WIDTH, 8, operand/result width in bits; legal range WIDTH ≥ 2
- clk  in  1  rising-edge clock
- rst  in  1  reset; asynchronous, active-high
- start  in  1  request; sampled only in IDLE
- a  in  WIDTH  operand A; latched on accepted start
- b  in  WIDTH  operand B; latched on accepted start
- cin  in  1  carry-in; latched on accepted start
- sub  in  1  subtract request; present only with SERIAL_ADD_SUB_EN; latched on accepted start
- busy  out  1  high while bits are being computed
- done  out  1  one-cycle pulse; result valid
- sum  out  WIDTH  result register
- cout  out  1  final carry register

## Operation
- States: IDLE, ADD, DONE.
- **IDLE**
  - busy=0.
  - start=1 loads shift registers sa←a and sb←b.
  - Loads carry←cin and bit counter←0.
  - Next state is ADD.
- **ADD**
  - busy=1.
  - Full-adder cell inputs: sa[0], sb[0], carry.
  - Cell sum bit shifts into a WIDTH-bit accumulator from the MSB end; sa and sb shift right by one.
  - carry←cell cout.
  - counter increments; counter width is $clog2(WIDTH).
  - When counter==WIDTH-1 (last bit):
    - sum←completed accumulator, including this cycle's bit.
    - cout←this cycle's cell cout.
    - Next state is DONE.
- **DONE**
  - done=1 and busy=0 for exactly one cycle.
  - Next state is IDLE unconditionally.
  - start is ignored in this cycle.
- start is ignored in ADD and DONE; no queuing.
- Operand, cin and sub changes after acceptance have no effect.
- sum and cout change only on the last ADD cycle. They hold their value through IDLE and through the following operation until its last bit.
- Arithmetic is modulo 2^WIDTH; cout is the true carry out of bit WIDTH-1.
- **Reset**
  - Any state → IDLE immediately.
  - busy=0, done=0, sum=0, cout=0.
  - Counter, carry, sa, sb and accumulator cleared.
  - Reset mid-operation aborts it with no done pulse.
  - First start after reset deassertion is accepted normally.

## Timing
- Start sampled high in IDLE at edge t:
  - busy is high for edges t+1 … t+WIDTH, i.e. WIDTH cycles.
  - done is high in the cycle after edge t+WIDTH.
  - sum and cout are valid from that cycle.
- Start-to-done latency: WIDTH+1 cycles.
- Back-to-back throughput: one operation per WIDTH+2 cycles. start may be held high; it is re-accepted in the first IDLE cycle.
- All outputs are registered; no combinational path from inputs to outputs.

## Configuration
- Macro: SERIAL_ADD_SUB_EN.
- **Defined**
  - sub port exists.
  - With sub latched as 1, each sb bit is inverted before the cell and the initial carry is forced to 1, ignoring cin.
  - Result is a−b mod 2^WIDTH; cout=1 means no borrow.
  - With sub=0, behaviour is identical to the undefined case.
- **Undefined**
  - No sub port and no inversion logic; addition only.

## Structure
- Package serial_add_pkg:
  - state typedef (IDLE/ADD/DONE) with fixed 2-bit encoding: IDLE=0, ADD=1, DONE=2.
  - Default WIDTH constant.
- Sub-module fa_cell: one-bit full adder.
  - Ports a, b, cin, sum, cout.
  - sum=a^b^cin; cout=ab|bcin|cina.
  - Instantiated once.
- Controller holds FSM, counter, carry flip-flop, shift and result registers.

## Test plan
- WIDTH=8, a=0x5A, b=0x33, cin=0:
  - busy high 8 cycles.
  - done pulse at start+9.
  - sum=0x8D, cout=0.
- a=0xFF, b=0x01, cin=0 → sum=0x00, cout=1.
- a=0xFF, b=0xFF, cin=1 → sum=0xFF, cout=1.
- start pulsed again while busy, with a=0x00, b=0x00:
  - Ignored; first result unchanged.
  - Exactly one done pulse.
  - Second start is accepted only after returning to IDLE.
- Reset asserted at ADD cycle 4:
  - Outputs zero immediately; no done pulse.
  - Next start with a=0x01, b=0x02 → sum=0x03.
- SERIAL_ADD_SUB_EN defined:
  - a=0x10, b=0x01, sub=1 → sum=0x0F, cout=1.
  - a=0x01, b=0x02, sub=1 → sum=0xFF, cout=0.
